behavioural_gate_bank: RTL and testbench

Registered bank of the seven basic two-input logic functions (AND, OR, NOR, NOT, NAND, XNOR, XOR) computed bitwise on operands `a` and `b`. It is the reference gate-level building block used for logic-function smoke tests and as a known-good comparison source. Outputs are registered, so all seven results update together on the same clock edge.

---
 rtl/behavioural_gate_bank_pkg.sv | 8 +
 rtl/behavioural_gate_bank_logic.sv | 27 ++
 rtl/behavioural_gate_bank.sv | 69 ++++++
 tb/tb_behavioural_gate_bank.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/behavioural_gate_bank_pkg.sv
// Shared constants for the registered gate bank.
// Holds the legal width bound used to validate the WIDTH parameter.
package behavioural_gate_bank_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int NUM_GATES = 7;

endpackage

// File: rtl/behavioural_gate_bank_logic.sv
// Combinational core: seven bitwise two-input functions of a and b.
// Ports: a, b (WIDTH) in; and/or/nor/not/nand/xnor/xor _c (WIDTH) out.
module behavioural_gate_bank_logic #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_c,
    output logic [WIDTH-1:0] or_c,
    output logic [WIDTH-1:0] nor_c,
    output logic [WIDTH-1:0] not_c,
    output logic [WIDTH-1:0] nand_c,
    output logic [WIDTH-1:0] xnor_c,
    output logic [WIDTH-1:0] xor_c
);

    always_comb begin
        and_c  = a & b;
        or_c   = a | b;
        nor_c  = ~(a | b);
        not_c  = ~a;
        nand_c = ~(a & b);
        xnor_c = ~(a ^ b);
        xor_c  = a ^ b;
    end

endmodule

// File: rtl/behavioural_gate_bank.sv
// Registered bank of seven bitwise logic functions, 1-cycle latency.
// Ports: clk, rst (async, active-high), a, b in; seven WIDTH-bit results out.
module behavioural_gate_bank
    import behavioural_gate_bank_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] not_out,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] xnor_out,
    output logic [WIDTH-1:0] xor_out
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("behavioural_gate_bank: WIDTH out of range");
    end

    logic [WIDTH-1:0] and_c;
    logic [WIDTH-1:0] or_c;
    logic [WIDTH-1:0] nor_c;
    logic [WIDTH-1:0] not_c;
    logic [WIDTH-1:0] nand_c;
    logic [WIDTH-1:0] xnor_c;
    logic [WIDTH-1:0] xor_c;

    behavioural_gate_bank_logic #(
        .WIDTH (WIDTH)
    ) u_logic (
        .a      (a),
        .b      (b),
        .and_c  (and_c),
        .or_c   (or_c),
        .nor_c  (nor_c),
        .not_c  (not_c),
        .nand_c (nand_c),
        .xnor_c (xnor_c),
        .xor_c  (xor_c)
    );

    // Reset forces zeros on every output, including the inverting ones;
    // these are not the gate results for a=b=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_out  <= '0;
            or_out   <= '0;
            nor_out  <= '0;
            not_out  <= '0;
            nand_out <= '0;
            xnor_out <= '0;
            xor_out  <= '0;
        end else begin
            and_out  <= and_c;
            or_out   <= or_c;
            nor_out  <= nor_c;
            not_out  <= not_c;
            nand_out <= nand_c;
            xnor_out <= xnor_c;
            xor_out  <= xor_c;
        end
    end

endmodule

// File: tb/tb_behavioural_gate_bank.sv
// Self-checking bench for behavioural_gate_bank at WIDTH=1 and WIDTH=8.
// Result packing everywhere: {and, or, nor, not, nand, xnor, xor}.
module tb_behavioural_gate_bank;

    logic       clk;
    logic       rst;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic and1, or1, nor1, not1, nand1, xnor1, xor1;
    logic [7:0] and8, or8, nor8, not8, nand8, xnor8, xor8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic [6:0] e;
    } vec1_t;

    typedef struct {
        string      name;
        logic [6:0]  e1;
        logic [55:0] e8;
        bit          use8;
    } exp_t;

    vec1_t tbl[7];
    exp_t  sb[$];

    behavioural_gate_bank #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .a        (a1),
        .b        (b1),
        .and_out  (and1),
        .or_out   (or1),
        .nor_out  (nor1),
        .not_out  (not1),
        .nand_out (nand1),
        .xnor_out (xnor1),
        .xor_out  (xor1)
    );

    behavioural_gate_bank #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .a        (a8),
        .b        (b8),
        .and_out  (and8),
        .or_out   (or8),
        .nor_out  (nor8),
        .not_out  (not8),
        .nand_out (nand8),
        .xnor_out (xnor8),
        .xor_out  (xor8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pk1();
        return {and1, or1, nor1, not1, nand1, xnor1, xor1};
    endfunction

    function automatic logic [55:0] pk8();
        return {and8, or8, nor8, not8, nand8, xnor8, xor8};
    endfunction

    function automatic logic [6:0] m1(logic x, logic y);
        return {x & y, x | y, ~(x | y), ~x, ~(x & y), ~(x ^ y), x ^ y};
    endfunction

    function automatic logic [55:0] m8(logic [7:0] x, logic [7:0] y);
        return {x & y, x | y, ~(x | y), ~x, ~(x & y), ~(x ^ y), x ^ y};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Called #1 after a rising edge: drive, queue expectation, then
    // compare the popped entry #1 after the capturing edge.
    task automatic drive(string nm, logic x1, logic y1,
                         logic [7:0] x8, logic [7:0] y8,
                         logic [6:0] e1, logic [55:0] e8, bit u8);
        exp_t e;
        a1 = x1;
        b1 = y1;
        a8 = x8;
        b8 = y8;
        e.name = nm;
        e.e1   = e1;
        e.e8   = e8;
        e.use8 = u8;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_w1"}, {57'd0, pk1()}, {57'd0, e.e1});
            if (e.use8)
                chk({e.name, "_w8"}, {8'd0, pk8()}, {8'd0, e.e8});
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 7'b0011110};
        tbl[1] = '{1'b1, 1'b0, 7'b0100101};
        tbl[2] = '{1'b0, 1'b1, 7'b0101101};
        tbl[3] = '{1'b1, 1'b1, 7'b1100010};
        tbl[4] = '{1'b1, 1'b0, 7'b0100101};
        tbl[5] = '{1'b0, 1'b1, 7'b0101101};
        tbl[6] = '{1'b1, 1'b1, 7'b1100010};

        rst = 1'b1;
        a1  = 1'b1;
        b1  = 1'b1;
        a8  = 8'hFF;
        b8  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_w1", {57'd0, pk1()}, 64'd0);
            chk("reset_w8", {8'd0, pk8()}, 64'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            drive($sformatf("sweep%0d", i), tbl[i].a, tbl[i].b,
                  8'h00, 8'h00, tbl[i].e, 56'd0, 1'b0);

        drive("w8_f0_3c", 1'b0, 1'b0, 8'hF0, 8'h3C, 7'b0011110,
              56'h30_FC_03_0F_CF_33_CC, 1'b1);

        drive("lat_pre", 1'b0, 1'b1, 8'h00, 8'h00,
              7'b0101101, 56'd0, 1'b0);
        a1 = 1'b1;
        #3;
        chk("lat_hold", {57'd0, pk1()}, {57'd0, 7'b0101101});
        @(posedge clk);
        #1;
        chk("lat_edge", {57'd0, pk1()}, {57'd0, 7'b1100010});

        drive("ar_pre", 1'b1, 1'b0, 8'h00, 8'h00,
              7'b0100101, 56'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("ar_async_w1", {57'd0, pk1()}, 64'd0);
        chk("ar_async_w8", {8'd0, pk8()}, 64'd0);
        #1 rst = 1'b0;
        #1;
        chk("ar_held", {57'd0, pk1()}, 64'd0);
        @(posedge clk);
        #1;
        chk("ar_release", {57'd0, pk1()}, {57'd0, 7'b0100101});

        for (int i = 0; i < 1000; i++) begin
            logic       x1, y1;
            logic [7:0] x8, y8;
            x1 = 1'($urandom_range(1));
            y1 = 1'($urandom_range(1));
            x8 = 8'($urandom);
            y8 = 8'($urandom);
            drive("soak", x1, y1, x8, y8, m1(x1, y1), m8(x8, y8), 1'b1);
            chk("inv_nand", {56'd0, nand8}, {56'd0, ~and8});
            chk("inv_nor",  {56'd0, nor8},  {56'd0, ~or8});
            chk("inv_xnor", {56'd0, xnor8}, {56'd0, ~xor8});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
